reg_access_ctrl: RTL and testbench

Initiator-side sequencer for the single-port register file. It accepts operand-fetch requests (rs1, rs2) and writeback requests (rd, data) from the core pipeline. It serialises them onto the register file's single address/read/write port and gathers the two read results, which arrive one cycle after each read. It returns both operands on a valid/ready response channel. It sits between decode/writeback logic and the register file, owns x0 hard-zero semantics, and enforces the write-to-read settling gap.

---
 rtl/reg_access_ctrl_pkg.sv | 32 +++
 rtl/reg_access_ctrl_if.sv | 40 ++++
 rtl/reg_rd_capture.sv | 49 ++++
 rtl/reg_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_reg_access_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_access_ctrl_pkg.sv
// Shared types and constants for the register-file access sequencer.
package reg_access_ctrl_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned WR_GAP_DEF = 2;
  localparam int unsigned NUM_SLOTS  = 2;

  localparam logic SLOT_RS1 = 1'b0;
  localparam logic SLOT_RS2 = 1'b1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [REG_WIDTH-1:0]  data_t;

  localparam addr_t X0_ADDR = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WR_WAIT,
    ST_RD1,
    ST_RD2,
    ST_CAP,
    ST_RSP
  } state_e;

  typedef struct packed {
    addr_t rd;
    data_t data;
  } wb_req_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Pipeline-side request/response channels plus the register-file port.
interface reg_access_ctrl_if;
  import reg_access_ctrl_pkg::*;

  logic  op_req_valid;
  logic  op_req_ready;
  addr_t op_rs1;
  addr_t op_rs2;
  logic  op_rsp_valid;
  logic  op_rsp_ready;
  data_t op_rs1_data;
  data_t op_rs2_data;
  logic  wb_valid;
  logic  wb_ready;
  addr_t wb_rd;
  data_t wb_data;
  logic  rf_read_en;
  logic  rf_write_en;
  addr_t rf_addr;
  data_t rf_wr_data;
  logic  rf_rd_data_val;
  data_t rf_rd_data;

  modport master (
    output op_req_valid, op_rs1, op_rs2, op_rsp_ready,
    output wb_valid, wb_rd, wb_data,
    output rf_rd_data_val, rf_rd_data,
    input  op_req_ready, op_rsp_valid, op_rs1_data, op_rs2_data,
    input  wb_ready, rf_read_en, rf_write_en, rf_addr, rf_wr_data
  );

  modport slave (
    input  op_req_valid, op_rs1, op_rs2, op_rsp_ready,
    input  wb_valid, wb_rd, wb_data,
    input  rf_rd_data_val, rf_rd_data,
    output op_req_ready, op_rsp_valid, op_rs1_data, op_rs2_data,
    output wb_ready, rf_read_en, rf_write_en, rf_addr, rf_wr_data
  );

endinterface

// File: rtl/reg_rd_capture.sv
// Collects the two read results in arrival order; x0 slots capture zero.
module reg_rd_capture
  import reg_access_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  logic  clr_i,
  input  logic  val_i,
  input  data_t data_i,
  input  addr_t addr0_i,
  input  addr_t addr1_i,
  output data_t slot0_o,
  output data_t slot1_o,
  output logic  both_full_o,
  output logic  last_cap_o
);

  logic                             ptr_q;
  logic                             full_q;
  logic [NUM_SLOTS-1:0][REG_WIDTH-1:0] slot_q;
  logic                             cap;
  addr_t                            cur_addr;

  assign cap      = en_i & val_i & ~full_q;
  assign cur_addr = (ptr_q == SLOT_RS2) ? addr1_i : addr0_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= SLOT_RS1;
      full_q <= 1'b0;
      slot_q <= '0;
    end else if (clr_i) begin
      ptr_q  <= SLOT_RS1;
      full_q <= 1'b0;
    end else if (cap) begin
      slot_q[ptr_q] <= (cur_addr == X0_ADDR) ? '0 : data_i;
      if (ptr_q == SLOT_RS2) full_q <= 1'b1;
      else                   ptr_q  <= SLOT_RS2;
    end
  end

  // last_cap_o lets the sequencer leave CAP on the same edge the second slot fills
  assign last_cap_o  = cap & (ptr_q == SLOT_RS2);
  assign both_full_o = full_q;
  assign slot0_o     = slot_q[SLOT_RS1];
  assign slot1_o     = slot_q[SLOT_RS2];

endmodule

// File: rtl/reg_access_ctrl.sv
// Serialises operand fetches and writebacks onto the single-port register file.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int unsigned WR_GAP = WR_GAP_DEF
) (
  input logic              clk,
  input logic              rst_n,
  reg_access_ctrl_if.slave bus
);

  localparam int unsigned       CNT_W    = (WR_GAP > 2) ? $clog2(WR_GAP - 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WR_GAP > 1) ? WR_GAP - 2 : 0);

  state_e           state_q, state_d;
  wb_req_t          wb_q, wb_d;
  addr_t            rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;
  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  addr_t            rf_addr_q, rf_addr_d;
  data_t            rf_wdata_q, rf_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic  both_full, last_cap, cap_en, cap_clr;
  data_t slot0, slot1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wb_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cnt_q       <= '0;
      idle_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next state, then register-file strobes decoded from the state being entered
  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (idle_q) begin
          if (bus.wb_valid) begin
            if (bus.wb_rd != X0_ADDR) begin
              wb_d    = '{rd: bus.wb_rd, data: bus.wb_data};
              state_d = ST_WRITE;
            end
          end else if (bus.op_req_valid) begin
            rs1_d   = bus.op_rs1;
            rs2_d   = bus.op_rs2;
            state_d = ST_RD1;
          end
        end
      end
      ST_WRITE: begin
        cnt_d   = CNT_LOAD;
        state_d = (WR_GAP > 1) ? ST_WR_WAIT : ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_CAP;
      ST_CAP:  if (both_full || last_cap) state_d = ST_RSP;
      ST_RSP:  if (bus.op_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WRITE: begin
        wr_en_d    = 1'b1;
        rf_addr_d  = wb_d.rd;
        rf_wdata_d = wb_d.data;
      end
      ST_RD1: begin
        rd_en_d   = 1'b1;
        rf_addr_d = rs1_d;
      end
      ST_RD2: begin
        rd_en_d   = 1'b1;
        rf_addr_d = rs2_d;
      end
      ST_RSP:  rsp_valid_d = 1'b1;
      default: ;
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  assign cap_en  = (state_q == ST_RD2) || (state_q == ST_CAP);
  assign cap_clr = (state_q == ST_RSP) && bus.op_rsp_ready;

  reg_rd_capture u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (cap_en),
    .clr_i       (cap_clr),
    .val_i       (bus.rf_rd_data_val),
    .data_i      (bus.rf_rd_data),
    .addr0_i     (rs1_q),
    .addr1_i     (rs2_q),
    .slot0_o     (slot0),
    .slot1_o     (slot1),
    .both_full_o (both_full),
    .last_cap_o  (last_cap)
  );

  // Writeback wins in IDLE, so the fetch ready has to see wb_valid directly
  assign bus.wb_ready     = idle_q;
  assign bus.op_req_ready = idle_q & ~bus.wb_valid;
  assign bus.op_rsp_valid = rsp_valid_q;
  assign bus.op_rs1_data  = slot0;
  assign bus.op_rs2_data  = slot1;
  assign bus.rf_read_en   = rd_en_q;
  assign bus.rf_write_en  = wr_en_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wr_data   = rf_wdata_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a small register-file model.
module tb_reg_access_ctrl;

  localparam int unsigned WR_GAP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_access_ctrl_if bus ();

  reg_access_ctrl #(.WR_GAP(WR_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk, n_err, cyc, wr_cnt, ovl_cnt, rd_start;
  bit delay2;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: read data one cycle after the read strobe, optional extra delay on the second read
  bit [31:0] mem [16];
  bit        pv  [8];
  bit [31:0] pd  [8];
  bit        prev_rd;
  bit [31:0] rv;

  always @(negedge clk) begin
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[7] = 1'b0;
    pd[7] = 32'h0;
    if (bus.rf_write_en) begin
      mem[bus.rf_addr] = bus.rf_wr_data;
      wr_cnt++;
    end
    if (bus.rf_read_en && bus.rf_write_en) ovl_cnt++;
    if (bus.rf_read_en) begin
      rv = (bus.rf_addr == 4'd0) ? 32'hFFFF_FFFF : mem[bus.rf_addr];
      if (delay2 && prev_rd) begin
        pv[4] = 1'b1;
        pd[4] = rv;
      end else begin
        pv[1] = 1'b1;
        pd[1] = rv;
      end
      if (!prev_rd) rd_start = cyc;
    end
    prev_rd            = bus.rf_read_en;
    bus.rf_rd_data_val = pv[0];
    bus.rf_rd_data     = pv[0] ? pd[0] : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic send_wb(input logic [3:0] rd, input logic [31:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
    #1;
    while (!bus.wb_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wb_accept", 64'(n < 50), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic send_op(input logic [3:0] r1, input logic [3:0] r2, output int acc);
    int n = 0;
    @(negedge clk);
    bus.op_req_valid = 1'b1;
    bus.op_rs1       = r1;
    bus.op_rs2       = r2;
    #1;
    while (!bus.op_req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("op_accept", 64'(n < 50), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    bus.op_req_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [31:0] e1, input logic [31:0] e2, input int hold, output int vc);
    int n = 0;
    @(negedge clk);
    while (!bus.op_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 64'(n < 50), 64'd1);
    vc = cyc;
    check("rs1_data", 64'(bus.op_rs1_data), 64'(e1));
    check("rs2_data", 64'(bus.op_rs2_data), 64'(e2));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.op_rsp_valid), 64'd1);
      check("bp_rs1", 64'(bus.op_rs1_data), 64'(e1));
      check("bp_rs2", 64'(bus.op_rs2_data), 64'(e2));
      check("bp_req_ready", 64'(bus.op_req_ready), 64'd0);
    end
    bus.op_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.op_rsp_ready = 1'b0;
    check("rsp_dropped", 64'(bus.op_rsp_valid), 64'd0);
    check("rsp_to_idle", 64'(bus.wb_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_ready"}, 64'(bus.wb_ready), 64'd0);
    check({tag, "_op_req_ready"}, 64'(bus.op_req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.op_rsp_valid), 64'd0);
    check({tag, "_rs_data"}, {bus.op_rs1_data, bus.op_rs2_data}, 64'd0);
    check({tag, "_rf_strobes"}, 64'({bus.rf_read_en, bus.rf_write_en}), 64'd0);
    check({tag, "_rf_addr"}, 64'(bus.rf_addr), 64'd0);
    check({tag, "_rf_wr_data"}, 64'(bus.rf_wr_data), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int acc, acc2, vc, w0;
    rst_n            = 1'b0;
    bus.op_req_valid = 1'b0;
    bus.op_rs1       = '0;
    bus.op_rs2       = '0;
    bus.op_rsp_ready = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    delay2           = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Write then read back, rs2 = x0
    w0 = wr_cnt;
    send_wb(4'd5, 32'hDEAD_BEEF, acc);
    send_op(4'd5, 4'd0, acc2);
    check("wr_to_rd_accept", 64'(acc2), 64'(acc + int'(WR_GAP) + 1));
    get_rsp(32'hDEAD_BEEF, 32'h0, 0, vc);
    check("rd_latency", 64'(vc), 64'(acc2 + 4));
    check("rd_after_wr_gap", 64'(rd_start - acc >= 4), 64'd1);
    check("wr_pulses", 64'(wr_cnt - w0), 64'd1);

    // x0 writeback is swallowed
    w0 = wr_cnt;
    send_wb(4'd0, 32'h0000_1234, acc);
    check("x0_stay_idle", 64'(bus.wb_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("x0_no_write", 64'(wr_cnt - w0), 64'd0);
    send_op(4'd0, 4'd0, acc2);
    get_rsp(32'h0, 32'h0, 0, vc);

    // Simultaneous writeback and fetch: writeback first
    @(negedge clk);
    bus.wb_valid     = 1'b1;
    bus.wb_rd        = 4'd7;
    bus.wb_data      = 32'h7777_0007;
    bus.op_req_valid = 1'b1;
    bus.op_rs1       = 4'd7;
    bus.op_rs2       = 4'd5;
    #1;
    check("simul_wb_ready", 64'(bus.wb_ready), 64'd1);
    check("simul_op_blocked", 64'(bus.op_req_ready), 64'd0);
    acc = cyc;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    send_op(4'd7, 4'd5, acc2);
    check("simul_op_accept", 64'(acc2), 64'(acc + int'(WR_GAP) + 1));
    get_rsp(32'h7777_0007, 32'hDEAD_BEEF, 0, vc);

    // Response back-pressure
    send_wb(4'd3, 32'h0000_000A, acc);
    send_wb(4'd4, 32'h0000_000B, acc);
    send_op(4'd3, 4'd4, acc2);
    get_rsp(32'h0000_000A, 32'h0000_000B, 10, vc);
    check("bp_latency", 64'(vc), 64'(acc2 + 4));

    // Second read data delayed by three cycles
    delay2 = 1'b1;
    send_op(4'd7, 4'd5, acc2);
    get_rsp(32'h7777_0007, 32'hDEAD_BEEF, 0, vc);
    check("delayed_latency", 64'(vc), 64'(acc2 + 7));
    delay2 = 1'b0;

    // Reset during RD2
    send_op(4'd3, 4'd4, acc2);
    @(posedge clk);
    #1;
    check("rd2_strobe", 64'({bus.rf_read_en, bus.rf_addr}), 64'({1'b1, 4'd4}));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 64'(bus.wb_ready), 64'd1);
    send_op(4'd4, 4'd3, acc2);
    get_rsp(32'h0000_000B, 32'h0000_000A, 0, vc);
    check("post_reset_latency", 64'(vc), 64'(acc2 + 4));

    check("rw_overlap", 64'(ovl_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
